// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, sizing helper and sample bundle for the CIC section
//
// Contents:
//   clog2            - ceil(log2(value)), used to size channel tags
//   CIC_DEF_*        - default widths/counts of the integrator chain
//   CIC_MAX_*        - supported upper limits for stages and channels
//   cic_sample_t     - data/chan/valid bundle at default widths, as consumed by the comb section
package cic_pkg;

    localparam int CIC_MAX_STAGES   = 8;
    localparam int CIC_MAX_CHANNELS = 16;

    localparam int CIC_DEF_IN_WIDTH = 24;
    localparam int CIC_DEF_WIDTH    = 48;
    localparam int CIC_DEF_STAGES   = 5;
    localparam int CIC_DEF_CHANNELS = 2;
    localparam int CIC_DEF_CH_BITS  = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic signed [CIC_DEF_WIDTH-1:0] data;
        logic [CIC_DEF_CH_BITS-1:0]      chan;
        logic                            valid;
    } cic_sample_t;

endpackage

// File: rtl/cic_int_stage.sv
// rtl/cic_int_stage.sv - one time-multiplexed integrator stage with per-channel accumulators
//
// Ports:
//   clock, reset_n      - rising-edge clock, asynchronous active-low reset
//   clear               - synchronous clear of all accumulators and the output register
//   in_valid/in_chan/in_data    - incoming sample, its channel tag and value
//   out_valid/out_chan/out_data - registered running sum for the tagged channel
module cic_int_stage
    import cic_pkg::*;
#(
    parameter int WIDTH    = CIC_DEF_WIDTH,
    parameter int CH_BITS  = CIC_DEF_CH_BITS,
    parameter int CHANNELS = CIC_DEF_CHANNELS
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [CH_BITS-1:0]         in_chan,
    input  logic signed [WIDTH-1:0]    in_data,
    output logic                       out_valid,
    output logic [CH_BITS-1:0]         out_chan,
    output logic signed [WIDTH-1:0]    out_data
);

    logic signed [WIDTH-1:0] acc_q [CHANNELS];
    logic signed [WIDTH-1:0] acc_d [CHANNELS];
    logic                    out_valid_q, out_valid_d;
    logic [CH_BITS-1:0]      out_chan_q,  out_chan_d;
    logic signed [WIDTH-1:0] out_data_q,  out_data_d;

    logic signed [WIDTH-1:0] sel_acc;
    logic signed [WIDTH-1:0] sum;

    // Channel select is done by comparison rather than array indexing so that
    // non-power-of-two channel counts never index past the array.
    always_comb begin
        sel_acc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_chan == CH_BITS'(c)) begin
                sel_acc = acc_q[c];
            end
        end
        // Plain modulo-2^WIDTH add: the comb section relies on wrap-around.
        sum = sel_acc + in_data;
    end

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_d[c] = '0;
            end
            out_chan_d = '0;
            out_data_d = '0;
        end else if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_chan == CH_BITS'(c)) begin
                    acc_d[c] = sum;
                end
            end
            out_valid_d = 1'b1;
            out_chan_d  = in_chan;
            out_data_d  = sum;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= acc_d[c];
            end
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/cic_integrator_chain.sv
// rtl/cic_integrator_chain.sv - cascaded, channel-multiplexed CIC integrator section
//
// Ports:
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   strobe/in_chan/in_data  - input sample valid, channel index, signed sample
//   out_strobe/out_chan/out_data - last-stage output, STAGES cycles after strobe
//   clear                   - synchronous clear, present only with CIC_INT_CLEAR_EN
//
// Build option: CIC_INT_CLEAR_EN adds the clear input; without it only reset_n
// clears the accumulators.
module cic_integrator_chain
    import cic_pkg::*;
#(
    parameter int IN_WIDTH = CIC_DEF_IN_WIDTH,
    parameter int WIDTH    = CIC_DEF_WIDTH,
    parameter int STAGES   = CIC_DEF_STAGES,
    parameter int CHANNELS = CIC_DEF_CHANNELS,
    parameter int CH_BITS  = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       strobe,
    input  logic [CH_BITS-1:0]         in_chan,
    input  logic signed [IN_WIDTH-1:0] in_data,
    output logic                       out_strobe,
    output logic [CH_BITS-1:0]         out_chan,
    output logic signed [WIDTH-1:0]    out_data
`ifdef CIC_INT_CLEAR_EN
    ,
    input  logic                       clear
`endif
);

    logic clr;
`ifdef CIC_INT_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    // Index k is the input of stage k; index STAGES is the chain output.
    logic                    vld [STAGES+1];
    logic [CH_BITS-1:0]      tag [STAGES+1];
    logic signed [WIDTH-1:0] dat [STAGES+1];

    // Out-of-range channel indices never enter the pipeline, so later stages
    // can trust every tag they see.
    assign vld[0] = strobe && (32'(in_chan) < 32'(CHANNELS));
    assign tag[0] = in_chan;
    assign dat[0] = WIDTH'(in_data);

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        cic_int_stage #(
            .WIDTH    (WIDTH),
            .CH_BITS  (CH_BITS),
            .CHANNELS (CHANNELS)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (clr),
            .in_valid  (vld[k]),
            .in_chan   (tag[k]),
            .in_data   (dat[k]),
            .out_valid (vld[k+1]),
            .out_chan  (tag[k+1]),
            .out_data  (dat[k+1])
        );
    end

    assign out_strobe = vld[STAGES];
    assign out_chan   = tag[STAGES];
    assign out_data   = dat[STAGES];

endmodule

// File: tb/tb_cic_integrator_chain.sv
// tb/tb_cic_integrator_chain.sv - directed self-checking bench for cic_integrator_chain
module tb_cic_integrator_chain;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // dut_a: 3 stages, 3 channels (2-bit tag), 24-bit in, 48-bit acc
    logic               a_strobe;
    logic [1:0]         a_chan;
    logic signed [23:0] a_data;
    logic               a_os;
    logic [1:0]         a_oc;
    logic signed [47:0] a_od;
`ifdef CIC_INT_CLEAR_EN
    logic               a_clear;
`endif

    // dut_b: 1 stage, 1 channel, 8-bit everywhere (wrap check)
    logic               b_strobe;
    logic [0:0]         b_chan;
    logic signed [7:0]  b_data;
    logic               b_os;
    logic [0:0]         b_oc;
    logic signed [7:0]  b_od;

    // dut_c: 2 stages, 2 channels
    logic               c_strobe;
    logic [0:0]         c_chan;
    logic signed [23:0] c_data;
    logic               c_os;
    logic [0:0]         c_oc;
    logic signed [47:0] c_od;

    cic_integrator_chain #(
        .IN_WIDTH(24), .WIDTH(48), .STAGES(3), .CHANNELS(3), .CH_BITS(2)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .strobe(a_strobe), .in_chan(a_chan),
        .in_data(a_data), .out_strobe(a_os), .out_chan(a_oc), .out_data(a_od)
`ifdef CIC_INT_CLEAR_EN
        , .clear(a_clear)
`endif
    );

    cic_integrator_chain #(
        .IN_WIDTH(8), .WIDTH(8), .STAGES(1), .CHANNELS(1), .CH_BITS(1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .strobe(b_strobe), .in_chan(b_chan),
        .in_data(b_data), .out_strobe(b_os), .out_chan(b_oc), .out_data(b_od)
`ifdef CIC_INT_CLEAR_EN
        , .clear(1'b0)
`endif
    );

    cic_integrator_chain #(
        .IN_WIDTH(24), .WIDTH(48), .STAGES(2), .CHANNELS(2), .CH_BITS(1)
    ) dut_c (
        .clock(clock), .reset_n(reset_n), .strobe(c_strobe), .in_chan(c_chan),
        .in_data(c_data), .out_strobe(c_os), .out_chan(c_oc), .out_data(c_od)
`ifdef CIC_INT_CLEAR_EN
        , .clear(1'b0)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic s, input logic [1:0] ch, input logic signed [23:0] d);
        a_strobe = s;
        a_chan   = ch;
        a_data   = d;
    endtask

    // Impulse into one channel of dut_a followed by zero samples on that channel.
    // Sample i lands on the output after the edge of step i+2.
    task automatic run_impulse_a(input logic [1:0] ch, input string tag);
        logic signed [47:0] exp_seq [5];
        exp_seq = '{48'sd1, 48'sd3, 48'sd6, 48'sd10, 48'sd15};
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, ch, (i == 0) ? 24'sd1 : 24'sd0);
            tick();
            if (i == 1) begin
                check($sformatf("%s_latency_strobe", tag), 64'(a_os), 64'sd0);
            end
            if (i >= 2) begin
                check($sformatf("%s_strobe_%0d", tag, i - 2), 64'(a_os), 64'sd1);
                check($sformatf("%s_chan_%0d", tag, i - 2), 64'(a_oc), 64'(ch));
                check($sformatf("%s_data_%0d", tag, i - 2), a_od, exp_seq[i-2]);
            end
        end
        drive_a(1'b0, 2'd0, 24'sd0);
        tick();
        tick();
        tick();
        // samples 5 and 6 reach 21 and 28; with strobe low the output then holds
        check($sformatf("%s_idle_strobe", tag), 64'(a_os), 64'sd0);
        check($sformatf("%s_idle_hold", tag), a_od, 64'sd28);
        check($sformatf("%s_idle_chan", tag), 64'(a_oc), 64'(ch));
    endtask

    initial begin
        logic signed [7:0]  wrap_exp [4];
        logic signed [47:0] c_exp    [3];
        wrap_exp = '{8'sd100, -8'sd56, 8'sd44, -8'sd112};
        c_exp    = '{48'sd1, 48'sd3, 48'sd6};

        drive_a(1'b0, 2'd0, 24'sd0);
`ifdef CIC_INT_CLEAR_EN
        a_clear = 1'b0;
`endif
        b_strobe = 1'b0; b_chan = 1'b0; b_data = '0;
        c_strobe = 1'b0; c_chan = 1'b0; c_data = '0;

        repeat (2) tick();
        check("rst_a_strobe", 64'(a_os), 64'sd0);
        check("rst_a_chan",   64'(a_oc), 64'sd0);
        check("rst_a_data",   a_od,      64'sd0);
        check("rst_b_data",   b_od,      64'sd0);
        check("rst_c_strobe", 64'(c_os), 64'sd0);
        reset_n = 1'b1;
        tick();

        // Invalid channel: in_chan=3 with CHANNELS=3 must vanish.
        drive_a(1'b1, 2'd3, 24'sd5);
        tick();
        drive_a(1'b0, 2'd0, 24'sd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("invalid_no_strobe_%0d", i), 64'(a_os), 64'sd0);
        end

        // Impulse on ch0: unaffected by the dropped 5.
        run_impulse_a(2'd0, "imp");

        // Step with wrap on dut_b: 100 per sample, modulo 256.
        for (int i = 0; i < 4; i++) begin
            b_strobe = 1'b1; b_chan = 1'b0; b_data = 8'sd100;
            tick();
            check($sformatf("wrap_strobe_%0d", i), 64'(b_os), 64'sd1);
            check($sformatf("wrap_data_%0d", i), b_od, wrap_exp[i]);
        end
        b_strobe = 1'b0;
        tick();
        check("wrap_idle_strobe", 64'(b_os), 64'sd0);
        check("wrap_idle_hold", b_od, -64'sd112);

        // Channel independence on dut_c: ch0=+1, ch1=-1 alternating.
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                c_strobe = 1'b1;
                c_chan   = 1'(i % 2);
                c_data   = (i % 2 == 0) ? 24'sd1 : -24'sd1;
            end else begin
                c_strobe = 1'b0;
            end
            tick();
            if (i == 0) begin
                check("chan_latency_strobe", 64'(c_os), 64'sd0);
            end else begin
                check($sformatf("chan_strobe_%0d", i - 1), 64'(c_os), 64'sd1);
                check($sformatf("chan_tag_%0d", i - 1), 64'(c_oc), 64'((i - 1) % 2));
                check($sformatf("chan_data_%0d", i - 1), c_od,
                      ((i - 1) % 2 == 0) ? c_exp[(i-1)/2] : -c_exp[(i-1)/2]);
            end
        end
        c_strobe = 1'b0;
        tick();
        check("chan_idle_strobe", 64'(c_os), 64'sd0);

        // Reset mid-stream: three ch1 samples of 4 in flight.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 2'd1, 24'sd4);
            tick();
        end
        check("pre_reset_strobe", 64'(a_os), 64'sd1);
        check("pre_reset_chan",   64'(a_oc), 64'sd1);
        check("pre_reset_data",   a_od,      64'sd4);
        drive_a(1'b0, 2'd0, 24'sd0);
        reset_n = 1'b0;
        #1;
        check("async_rst_strobe", 64'(a_os), 64'sd0);
        check("async_rst_chan",   64'(a_oc), 64'sd0);
        check("async_rst_data",   a_od,      64'sd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_no_strobe_%0d", i), 64'(a_os), 64'sd0);
        end
        run_impulse_a(2'd1, "rst_imp");

`ifdef CIC_INT_CLEAR_EN
        // Clear with a coincident strobe: sample dropped, state zeroed.
        drive_a(1'b1, 2'd1, 24'sd7);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        drive_a(1'b0, 2'd0, 24'sd0);
        check("clear_strobe", 64'(a_os), 64'sd0);
        check("clear_chan",   64'(a_oc), 64'sd0);
        check("clear_data",   a_od,      64'sd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("clear_no_strobe_%0d", i), 64'(a_os), 64'sd0);
        end
        run_impulse_a(2'd1, "clr_imp");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
